// File: rtl/alu_axot611_pkg.sv
// -----------------------------------------------------------------------------
// alu_axot611_pkg
// Shared definitions for the 4-bit TinyTapeout ALU tile.
//   op_e         : 4-bit opcode enumeration (OP_ADD .. OP_PASSB)
//   FLAG_Z/C/V   : bit positions of the status flags on uio_out
//   UIO_OE_MASK  : output-enable pattern for the bidirectional pins
//   is_zero()    : helper used to derive the Z flag from an 8-bit result
// Optional feature macro (consumed in alu_axot611_core): ALU_SATURATE_EN
// -----------------------------------------------------------------------------
package alu_axot611_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'h0,
        OP_SUB     = 4'h1,
        OP_MUL     = 4'h2,
        OP_AND     = 4'h3,
        OP_OR      = 4'h4,
        OP_XOR     = 4'h5,
        OP_NAND    = 4'h6,
        OP_NOT     = 4'h7,
        OP_SHL     = 4'h8,
        OP_SHR     = 4'h9,
        OP_ROL     = 4'hA,
        OP_CMP     = 4'hB,
        OP_INC     = 4'hC,
        OP_DEC     = 4'hD,
        OP_ABSDIFF = 4'hE,
        OP_PASSB   = 4'hF
    } op_e;

    localparam int FLAG_Z = 7;
    localparam int FLAG_C = 6;
    localparam int FLAG_V = 5;

    // Flags live on uio[7:5] and are driven; uio[4:0] stay inputs
    // so the opcode and valid strobe can arrive on them.
    localparam logic [7:0] UIO_OE_MASK = 8'hE0;

    function automatic logic is_zero(input logic [7:0] value);
        return (value == 8'h00);
    endfunction

endpackage

// File: rtl/alu_axot611_core.sv
// -----------------------------------------------------------------------------
// alu_axot611_core
// Purely combinational datapath of the ALU tile. Z is not produced here; the
// top derives it from the registered-to-be result.
// Ports:
//   a, b      in  4  unsigned operands
//   opcode    in  4  operation select (op_e)
//   result    out 8  zero-extended / full-width result
//   carry     out 1  carry or borrow for ADD, SUB, INC, DEC; 0 otherwise
//   overflow  out 1  4-bit signed overflow for ADD and SUB; 0 otherwise
// Optional feature macro: ALU_SATURATE_EN
//   When defined, ADD/INC clamp to 0x0F on carry-out and SUB/DEC clamp to 0x00
//   on borrow. carry still reports the unclamped carry/borrow.
// -----------------------------------------------------------------------------
module alu_axot611_core
    import alu_axot611_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  op_e        opcode,
    output logic [7:0] result,
    output logic       carry,
    output logic       overflow
);

    logic [7:0] a_ext;
    logic [7:0] b_ext;
    logic [4:0] sum5;
    logic [7:0] diff8;
    logic       borrow;
    logic [4:0] inc5;
    logic [7:0] dec8;
    logic       add_v;
    logic       sub_v;
    logic [1:0] shamt;
    logic [7:0] rol_wide;
    logic [3:0] abs_diff;

    assign a_ext  = {4'b0000, a};
    assign b_ext  = {4'b0000, b};
    assign sum5   = {1'b0, a} + {1'b0, b};
    assign diff8  = a_ext - b_ext;
    assign borrow = (a < b);
    assign inc5   = {1'b0, a} + 5'd1;
    assign dec8   = a_ext - 8'd1;
    assign shamt  = b[1:0];

    // Signed overflow: operands of equal sign producing a sum of the other
    // sign (ADD), or operands of differing sign where the difference takes
    // the sign of the subtrahend (SUB). Bit 3 of diff8 equals bit 3 of the
    // 4-bit difference, so it serves as the signed result's sign.
    assign add_v = (a[3] == b[3]) && (sum5[3] != a[3]);
    assign sub_v = (a[3] != b[3]) && (diff8[3] != a[3]);

    // Rotating within a nibble: shift two copies of A left and keep the
    // upper nibble, which then holds the wrapped-around bits.
    assign rol_wide = {a, a} << shamt;

    assign abs_diff = borrow ? (b - a) : (a - b);

    // Operation select. Every output gets a default first so unused paths
    // report C=V=0 and no latches form.
    always_comb begin
        result   = 8'h00;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                result   = {3'b000, sum5};
                carry    = sum5[4];
                overflow = add_v;
`ifdef ALU_SATURATE_EN
                if (sum5[4]) result = 8'h0F;
`endif
            end
            OP_SUB: begin
                result   = diff8;
                carry    = borrow;
                overflow = sub_v;
`ifdef ALU_SATURATE_EN
                if (borrow) result = 8'h00;
`endif
            end
            OP_MUL:     result = a_ext * b_ext;
            OP_AND:     result = {4'b0000, a & b};
            OP_OR:      result = {4'b0000, a | b};
            OP_XOR:     result = {4'b0000, a ^ b};
            OP_NAND:    result = {4'b0000, ~(a & b)};
            OP_NOT:     result = {4'b0000, ~a};
            OP_SHL:     result = a_ext << shamt;
            OP_SHR:     result = a_ext >> shamt;
            OP_ROL:     result = {4'b0000, rol_wide[7:4]};
            OP_CMP:     result = {5'b00000, (a > b), (a == b), (a < b)};
            OP_INC: begin
                result = {3'b000, inc5};
                carry  = inc5[4];
`ifdef ALU_SATURATE_EN
                if (inc5[4]) result = 8'h0F;
`endif
            end
            OP_DEC: begin
                result = dec8;
                carry  = (a == 4'h0);
`ifdef ALU_SATURATE_EN
                if (a == 4'h0) result = 8'h00;
`endif
            end
            OP_ABSDIFF: result = {4'b0000, abs_diff};
            OP_PASSB:   result = b_ext;
            default:    result = 8'h00;
        endcase
    end

endmodule

// File: rtl/tt_um_alu_axot611.sv
// -----------------------------------------------------------------------------
// tt_um_alu_axot611
// TinyTapeout user tile: 4-bit two-operand ALU with registered result/flags.
// Ports:
//   clk      in  1  system clock, rising edge
//   rst_n    in  1  asynchronous, active-low reset
//   ena      in  1  tile enable; registers hold while low
//   ui_in    in  8  [3:0] operand A, [7:4] operand B
//   uio_in   in  8  [3:0] opcode, [4] valid strobe, [7:5] ignored
//   uo_out   out 8  registered result
//   uio_out  out 8  [7] Z, [6] C, [5] V, [4:0] driven 0
//   uio_oe   out 8  constant 8'hE0
// Optional feature macro (implemented in alu_axot611_core): ALU_SATURATE_EN
// -----------------------------------------------------------------------------
module tt_um_alu_axot611
    import alu_axot611_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [3:0] op_a;
    logic [3:0] op_b;
    op_e        opcode;
    logic       valid;
    logic [7:0] core_result;
    logic       core_carry;
    logic       core_overflow;
    logic [7:0] result_q;
    logic       z_q;
    logic       c_q;
    logic       v_q;
    logic       unused_pins;

    assign op_a   = ui_in[3:0];
    assign op_b   = ui_in[7:4];
    assign opcode = op_e'(uio_in[3:0]);
    assign valid  = uio_in[4];

    // uio_in[7:5] are spare pins with no function in this tile.
    assign unused_pins = &{1'b0, uio_in[7:5]};

    alu_axot611_core u_core (
        .a        (op_a),
        .b        (op_b),
        .opcode   (opcode),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow)
    );

    // Result and flag registers. A new result is taken only when the tile
    // is selected and the valid strobe is high; otherwise everything holds,
    // which is what lets the harness deselect the tile without losing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 8'h00;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else if (ena && valid) begin
            result_q <= core_result;
            z_q      <= is_zero(core_result);
            c_q      <= core_carry;
            v_q      <= core_overflow;
        end
    end

    // Pin mapping: flags sit on the upper three bidirectional pins, the rest
    // of uio_out is tied low and only the flag pins are output-enabled.
    always_comb begin
        uio_out         = 8'h00;
        uio_out[FLAG_Z] = z_q;
        uio_out[FLAG_C] = c_q;
        uio_out[FLAG_V] = v_q;
    end

    assign uo_out = result_q;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_alu_axot611.sv
// -----------------------------------------------------------------------------
// tb_tt_um_alu_axot611
// Self-checking bench for the ALU tile: directed vector table, hold/reset/
// throughput sequences, and randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_tt_um_alu_axot611;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
    } ref_t;

    typedef struct {
        string      name;
        int         a;
        int         b;
        int         op;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    tt_um_alu_axot611 dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded run time so a stuck bench still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Maps a 4-bit pattern onto its two's-complement value.
    function automatic int signed4(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference behaviour expressed with plain integer arithmetic.
    function automatic ref_t model(input int a, input int b, input int op);
        ref_t r;
        int   s;
        int   k;
        r.res = 8'h00;
        r.c   = 1'b0;
        r.v   = 1'b0;
        k     = b % 4;
        case (op)
            0: begin
                s     = a + b;
                r.res = 8'(s);
                r.c   = (s > 15);
                s     = signed4(a) + signed4(b);
                r.v   = (s > 7) || (s < -8);
`ifdef ALU_SATURATE_EN
                if (a + b > 15) r.res = 8'h0F;
`endif
            end
            1: begin
                r.res = 8'((a - b + 256) % 256);
                r.c   = (a < b);
                s     = signed4(a) - signed4(b);
                r.v   = (s > 7) || (s < -8);
`ifdef ALU_SATURATE_EN
                if (a < b) r.res = 8'h00;
`endif
            end
            2:  r.res = 8'(a * b);
            3:  r.res = 8'(a & b);
            4:  r.res = 8'(a | b);
            5:  r.res = 8'(a ^ b);
            6:  r.res = 8'(15 - (a & b));
            7:  r.res = 8'(15 - a);
            8:  r.res = 8'(a * (1 << k));
            9:  r.res = 8'(a / (1 << k));
            10: r.res = 8'(((a * (1 << k)) + (a / (1 << (4 - k)))) % 16);
            11: r.res = 8'((a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0));
            12: begin
                r.res = 8'(a + 1);
                r.c   = (a == 15);
`ifdef ALU_SATURATE_EN
                if (a == 15) r.res = 8'h0F;
`endif
            end
            13: begin
                r.res = 8'((a + 255) % 256);
                r.c   = (a == 0);
`ifdef ALU_SATURATE_EN
                if (a == 0) r.res = 8'h00;
`endif
            end
            14: r.res = 8'((a > b) ? a - b : b - a);
            default: r.res = 8'(b);
        endcase
        return r;
    endfunction

    // Drives operands, opcode and strobe; spare uio bits get a nonzero
    // pattern since the tile must ignore them.
    task automatic applyStimulus(input int a, input int b, input int op,
                                 input logic valid, input logic en);
        ui_in  = 8'((b << 4) | a);
        uio_in = {3'b101, valid, 4'(op)};
        ena    = en;
    endtask

    // Compares result, flag pins and output-enable pins.
    task automatic checkOutput(input string name, input logic [7:0] exp_res,
                               input logic exp_z, input logic exp_c, input logic exp_v);
        logic [7:0] exp_flags;
        exp_flags = {exp_z, exp_c, exp_v, 5'b00000};
        checks++;
        if (uo_out !== exp_res) begin
            errors++;
            $display("[TB] FAIL %s: uo_out=%h expected %h", name, uo_out, exp_res);
        end
        checks++;
        if (uio_out !== exp_flags) begin
            errors++;
            $display("[TB] FAIL %s: uio_out=%h expected %h", name, uio_out, exp_flags);
        end
        checks++;
        if (uio_oe !== 8'hE0) begin
            errors++;
            $display("[TB] FAIL %s: uio_oe=%h expected e0", name, uio_oe);
        end
    endtask

    task automatic checkModel(input string name, input ref_t r);
        checkOutput(name, r.res, (r.res == 8'h00), r.c, r.v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input int a, input int b, input int op,
                                input logic [7:0] res, input logic z, input logic c, input logic v);
        vec_t t;
        t.name = name; t.a = a; t.b = b; t.op = op;
        t.res = res; t.z = z; t.c = c; t.v = v;
        return t;
    endfunction

    initial begin
        ref_t cur;
        ref_t exp_q[$];
        int   ta[16];
        int   tb_b[16];

        // Directed vectors with hand-derived expectations.
`ifdef ALU_SATURATE_EN
        vecs.push_back(mk("add_15_15", 15, 15, 0, 8'h0F, 0, 1, 0));
        vecs.push_back(mk("sub_0_1",    0,  1, 1, 8'h00, 1, 1, 0));
        vecs.push_back(mk("inc_15",    15,  0, 12, 8'h0F, 0, 1, 0));
        vecs.push_back(mk("dec_0",      0,  0, 13, 8'h00, 1, 1, 0));
`else
        vecs.push_back(mk("add_15_15", 15, 15, 0, 8'h1E, 0, 1, 0));
        vecs.push_back(mk("sub_0_1",    0,  1, 1, 8'hFF, 0, 1, 0));
        vecs.push_back(mk("inc_15",    15,  0, 12, 8'h10, 0, 1, 0));
        vecs.push_back(mk("dec_0",      0,  0, 13, 8'hFF, 0, 1, 0));
`endif
        vecs.push_back(mk("sub_7_7",    7,  7, 1,  8'h00, 1, 0, 0));
        vecs.push_back(mk("sub_8_1",    8,  1, 1,  8'h07, 0, 0, 1));
        vecs.push_back(mk("add_7_1",    7,  1, 0,  8'h08, 0, 0, 1));
        vecs.push_back(mk("mul_15_15", 15, 15, 2,  8'hE1, 0, 0, 0));
        vecs.push_back(mk("cmp_3_9",    3,  9, 11, 8'h01, 0, 0, 0));
        vecs.push_back(mk("cmp_9_3",    9,  3, 11, 8'h04, 0, 0, 0));
        vecs.push_back(mk("rol_9_1",    9,  1, 10, 8'h03, 0, 0, 0));
        vecs.push_back(mk("shl_f_3",   15,  3, 8,  8'h78, 0, 0, 0));
        vecs.push_back(mk("shl_5_0",    5,  4, 8,  8'h05, 0, 0, 0));
        vecs.push_back(mk("shr_f_0",   15,  0, 9,  8'h0F, 0, 0, 0));
        vecs.push_back(mk("not_f",     15,  0, 7,  8'h00, 1, 0, 0));
        vecs.push_back(mk("nand_f_f",  15, 15, 6,  8'h00, 1, 0, 0));
        vecs.push_back(mk("xor_a_6",   10,  6, 5,  8'h0C, 0, 0, 0));
        vecs.push_back(mk("absdiff",    3,  9, 14, 8'h06, 0, 0, 0));
        vecs.push_back(mk("passb_0",    5,  0, 15, 8'h00, 1, 0, 0));

        // Reset state.
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 8'h00, 0, 0, 0);
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, 1'b1);
            tick();
            checkOutput(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v);
        end

        // Hold: valid low, then ena low, then a real capture.
        applyStimulus(15, 15, 0, 1'b1, 1'b1);
        tick();
        cur = model(15, 15, 0);
        checkModel("hold_setup", cur);
        applyStimulus(2, 3, 0, 1'b0, 1'b1);
        tick();
        checkModel("hold_valid0", cur);
        applyStimulus(2, 3, 0, 1'b1, 1'b0);
        tick();
        checkModel("hold_ena0", cur);
        applyStimulus(2, 3, 0, 1'b1, 1'b1);
        tick();
        checkOutput("hold_release", 8'h05, 0, 0, 0);

        // Asynchronous reset mid-cycle, away from any clock edge.
        applyStimulus(15, 15, 0, 1'b1, 1'b1);
        tick();
        checkModel("pre_reset", model(15, 15, 0));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 0, 0, 0);
        tick();
        checkOutput("reset_hold", 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(3, 9, 11, 1'b1, 1'b1);
        tick();
        checkOutput("post_reset", 8'h01, 0, 0, 0);

        // Throughput: every opcode on consecutive edges, valid held high.
        for (int i = 0; i < 16; i++) begin
            ta[i]   = $urandom_range(0, 15);
            tb_b[i] = $urandom_range(0, 15);
            exp_q.push_back(model(ta[i], tb_b[i], i));
        end
        applyStimulus(ta[0], tb_b[0], 0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            cur = exp_q.pop_front();
            checkModel($sformatf("stream_op%0d", i), cur);
            if (i < 15) applyStimulus(ta[i + 1], tb_b[i + 1], i + 1, 1'b1, 1'b1);
        end

        // Randomized traffic with random strobe and enable.
        for (int n = 0; n < 300; n++) begin
            int   a;
            int   b;
            int   op;
            logic v;
            logic e;
            a  = $urandom_range(0, 15);
            b  = $urandom_range(0, 15);
            op = $urandom_range(0, 15);
            v  = ($urandom_range(0, 3) != 0);
            e  = ($urandom_range(0, 4) != 0);
            applyStimulus(a, b, op, v, e);
            tick();
            if (v && e) cur = model(a, b, op);
            checkModel($sformatf("rand%0d_op%0d_a%0d_b%0d", n, op, a, b), cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
